// File: rtl/el2_bp_update_ctl_if.sv
// ---------------------------------------------------------------------------
// el2_bp_update_ctl_if
//   Bundle of all non-clock/reset signals of the branch-predictor update
//   controller: the EXU resolved-branch update handshake, the fetch-lookup
//   busy indication, the fence request/done pair, and the BTB/BHT write ports.
//
//   Parameters
//     IW  BTB/BHT index width
//     TW  BTB tag width
//     CW  BHT saturating counter width
//
//   Modports
//     master : EXU / fetch / fence side (drives updates, rd_busy, fence_req;
//              observes upd_ready, fence_done and the array write ports)
//     slave  : the update controller itself
// ---------------------------------------------------------------------------
interface el2_bp_update_ctl_if #(
    parameter int IW = 8,
    parameter int TW = 5,
    parameter int CW = 2
);
    // Resolved-branch update handshake
    logic          upd_valid;
    logic          upd_ready;
    logic [30:0]   upd_pc;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [11:0]   upd_toffset;
    logic [CW-1:0] upd_ctr;

    // Array arbitration and fence sequencing
    logic          rd_busy;
    logic          fence_req;
    logic          fence_done;

    // BTB write port
    logic          btb_wr_en;
    logic [IW-1:0] btb_wr_index;
    logic [TW-1:0] btb_wr_tag;
    logic [11:0]   btb_wr_toffset;
    logic          btb_wr_valid;

    // BHT write port
    logic          bht_wr_en;
    logic [IW-1:0] bht_wr_index;
    logic [CW-1:0] bht_wr_ctr;

    modport master (
        output upd_valid, upd_pc, upd_taken, upd_mispredict, upd_toffset, upd_ctr,
        output rd_busy, fence_req,
        input  upd_ready, fence_done,
        input  btb_wr_en, btb_wr_index, btb_wr_tag, btb_wr_toffset, btb_wr_valid,
        input  bht_wr_en, bht_wr_index, bht_wr_ctr
    );

    modport slave (
        input  upd_valid, upd_pc, upd_taken, upd_mispredict, upd_toffset, upd_ctr,
        input  rd_busy, fence_req,
        output upd_ready, fence_done,
        output btb_wr_en, btb_wr_index, btb_wr_tag, btb_wr_toffset, btb_wr_valid,
        output bht_wr_en, bht_wr_index, bht_wr_ctr
    );
endinterface

// File: rtl/el2_bp_update_ctl.sv
// ---------------------------------------------------------------------------
// el2_bp_update_ctl
//   Write side of the branch predictor arrays. Resolved-branch updates from
//   the EXU are hashed to a BTB/BHT index and tag at acceptance time and held
//   in a small FIFO. The FIFO head is written to the arrays on any cycle the
//   fetch lookup does not own them (rd_busy low). A fence request first drains
//   the FIFO and then walks every BTB index writing valid=0, finishing with a
//   one-cycle fence_done pulse.
//
//   Ports
//     clk    : clock
//     rst_l  : asynchronous active-low reset
//     bus    : el2_bp_update_ctl_if.slave
//                upd_*            update handshake (valid/ready) and payload
//                rd_busy          lookup owns the arrays; no pop this cycle
//                fence_req/done   invalidate request pulse / completion pulse
//                btb_wr_*         BTB write port (registered)
//                bht_wr_*         BHT write port (registered)
//
//   The index/tag hash here must match the lookup-side hash bit-for-bit.
// ---------------------------------------------------------------------------
module el2_bp_update_ctl #(
    parameter int BTB_ADDR_HI   = 9,
    parameter int BTB_ADDR_LO   = 2,
    parameter int BTB_BTAG_SIZE = 5,
    parameter int BHT_CTR_W     = 2,
    parameter int UPD_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    el2_bp_update_ctl_if.slave   bus
);

    localparam int IW   = BTB_ADDR_HI - BTB_ADDR_LO + 1;
    localparam int TW   = BTB_BTAG_SIZE;
    localparam int CW   = BHT_CTR_W;
    localparam int PW   = $clog2(UPD_DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   CTR_ONE  = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(UPD_DEPTH);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // One FIFO entry: hashed address plus everything needed to form the writes.
    typedef struct packed {
        logic [IW-1:0] index;
        logic [TW-1:0] tag;
        logic [11:0]   toffset;
        logic          taken;
        logic          mispredict;
        logic [CW-1:0] ctr;
    } entry_t;

    // Saturating counter step: never wraps past all-ones or below zero.
    function automatic logic [CW-1:0] next_ctr(input logic [CW-1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == '1) ? ctr : ctr + CTR_ONE;
        end
        return (ctr == '0) ? ctr : ctr - CTR_ONE;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,          state_d;
    logic [PW-1:0]   wr_ptr_q,         wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,         rd_ptr_d;
    logic [CNTW-1:0] count_q,          count_d;
    logic [IW-1:0]   clr_idx_q,        clr_idx_d;
    logic            upd_ready_q,      upd_ready_d;
    logic            fence_done_q,     fence_done_d;
    logic            btb_wr_en_q,      btb_wr_en_d;
    logic [IW-1:0]   btb_wr_index_q,   btb_wr_index_d;
    logic [TW-1:0]   btb_wr_tag_q,     btb_wr_tag_d;
    logic [11:0]     btb_wr_toffset_q, btb_wr_toffset_d;
    logic            btb_wr_valid_q,   btb_wr_valid_d;
    logic            bht_wr_en_q,      bht_wr_en_d;
    logic [IW-1:0]   bht_wr_index_q,   bht_wr_index_d;
    logic [CW-1:0]   bht_wr_ctr_q,     bht_wr_ctr_d;

    entry_t          mem [UPD_DEPTH];
    entry_t          enq_entry;
    entry_t          head;
    logic            enq;
    logic            pop;

    // Full byte-aligned PC; bit 0 is always zero for the halfword PC input.
    logic [31:0]     pc_full;
    logic            unused_pc_bits;

    assign pc_full        = {bus.upd_pc, 1'b0};
    assign unused_pc_bits = ^pc_full;

    // ------------------------------------------------------------------
    // Hash at enqueue: index folds the next IW bits above the index field
    // onto it; tag folds three TW-bit slices above the index field.
    // ------------------------------------------------------------------
    always_comb begin
        enq_entry.index      = pc_full[BTB_ADDR_HI:BTB_ADDR_LO]
                             ^ pc_full[BTB_ADDR_HI+IW:BTB_ADDR_HI+1];
        enq_entry.tag        = pc_full[BTB_ADDR_HI+TW:BTB_ADDR_HI+1]
                             ^ pc_full[BTB_ADDR_HI+2*TW:BTB_ADDR_HI+TW+1]
                             ^ pc_full[BTB_ADDR_HI+3*TW:BTB_ADDR_HI+2*TW+1];
        enq_entry.toffset    = bus.upd_toffset;
        enq_entry.taken      = bus.upd_taken;
        enq_entry.mispredict = bus.upd_mispredict;
        enq_entry.ctr        = bus.upd_ctr;
    end

    // ready is registered, so an accepted update always has a free slot and
    // a pop only frees space as seen by the following cycle's ready.
    assign enq  = bus.upd_valid & upd_ready_q;
    // Pop reads only registered occupancy: an entry enqueued this edge cannot
    // be written before the next cycle.
    assign pop  = (count_q != '0) & ~bus.rd_busy & (state_q != ST_CLEAR);
    assign head = mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (which would infer a latch).
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        clr_idx_d        = clr_idx_q;
        fence_done_d     = 1'b0;
        btb_wr_en_d      = 1'b0;
        btb_wr_index_d   = '0;
        btb_wr_tag_d     = '0;
        btb_wr_toffset_d = '0;
        btb_wr_valid_d   = 1'b0;
        bht_wr_en_d      = 1'b0;
        bht_wr_index_d   = '0;
        bht_wr_ctr_d     = '0;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({enq, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Head write: BHT always trains; BTB only learns taken mispredicts.
        if (pop) begin
            bht_wr_en_d    = 1'b1;
            bht_wr_index_d = head.index;
            bht_wr_ctr_d   = next_ctr(head.ctr, head.taken);
            if (head.mispredict && head.taken) begin
                btb_wr_en_d      = 1'b1;
                btb_wr_valid_d   = 1'b1;
                btb_wr_index_d   = head.index;
                btb_wr_tag_d     = head.tag;
                btb_wr_toffset_d = head.toffset;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.fence_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No new updates are accepted here, so an empty FIFO stays empty.
                if (count_q == '0) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (!bus.rd_busy) begin
                    btb_wr_en_d    = 1'b1;
                    btb_wr_valid_d = 1'b0;
                    btb_wr_index_d = clr_idx_q;
                    clr_idx_d      = clr_idx_q + IDX_ONE;
                    if (clr_idx_q == '1) begin
                        state_d      = ST_IDLE;
                        fence_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        upd_ready_d = (state_d == ST_IDLE) && (count_d != FULL_CNT);
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the entry array has no reset; occupancy is tracked by the reset pointers/count, so stale data is never read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= enq_entry;
        end
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            clr_idx_q        <= '0;
            upd_ready_q      <= 1'b0;
            fence_done_q     <= 1'b0;
            btb_wr_en_q      <= 1'b0;
            btb_wr_index_q   <= '0;
            btb_wr_tag_q     <= '0;
            btb_wr_toffset_q <= '0;
            btb_wr_valid_q   <= 1'b0;
            bht_wr_en_q      <= 1'b0;
            bht_wr_index_q   <= '0;
            bht_wr_ctr_q     <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            clr_idx_q        <= clr_idx_d;
            upd_ready_q      <= upd_ready_d;
            fence_done_q     <= fence_done_d;
            btb_wr_en_q      <= btb_wr_en_d;
            btb_wr_index_q   <= btb_wr_index_d;
            btb_wr_tag_q     <= btb_wr_tag_d;
            btb_wr_toffset_q <= btb_wr_toffset_d;
            btb_wr_valid_q   <= btb_wr_valid_d;
            bht_wr_en_q      <= bht_wr_en_d;
            bht_wr_index_q   <= bht_wr_index_d;
            bht_wr_ctr_q     <= bht_wr_ctr_d;
        end
    end

    assign bus.upd_ready      = upd_ready_q;
    assign bus.fence_done     = fence_done_q;
    assign bus.btb_wr_en      = btb_wr_en_q;
    assign bus.btb_wr_index   = btb_wr_index_q;
    assign bus.btb_wr_tag     = btb_wr_tag_q;
    assign bus.btb_wr_toffset = btb_wr_toffset_q;
    assign bus.btb_wr_valid   = btb_wr_valid_q;
    assign bus.bht_wr_en      = bht_wr_en_q;
    assign bus.bht_wr_index   = bht_wr_index_q;
    assign bus.bht_wr_ctr     = bht_wr_ctr_q;

endmodule
